// File: rtl/wb_cyc_ctrl.sv
`default_nettype none
// wb_cyc_ctrl: single-master Wishbone cycle controller, one outstanding request, registered outputs.
// Define WB_TIMEOUT_EN to add the bus-timeout error response.
module wb_cyc_ctrl #(
   parameter int AW      = 28,
   parameter int TIMEOUT = 255,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_vld_i,
   output logic          req_rdy_o,
   input  logic [AW-1:0] req_adr_i,
   input  logic          req_we_i,
   input  logic [31:0]   req_dat_i,
   input  logic [3:0]    req_sel_i,
   output logic          rsp_vld_o,
   input  logic          rsp_rdy_i,
   output logic [31:0]   rsp_dat_o,
   output logic          rsp_err_o,
   output logic          cyc_o,
   output logic          stb_o,
   output logic [AW-1:0] adr_o,
   output logic          we_o,
   output logic [31:0]   dat_o,
   output logic [3:0]    sel_o,
   input  logic          ack_i,
   input  logic [31:0]   dat_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          req_rdy_nxt;
   logic          rsp_vld_nxt;
   logic          bus_nxt;
   logic [AW-1:0] adr_nxt;
   logic          we_nxt;
   logic [31:0]   dat_nxt;
   logic [3:0]    sel_nxt;
   logic [31:0]   rsp_dat_nxt;

`ifdef WB_TIMEOUT_EN
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT);

   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_nxt;
   logic          rsp_err_nxt;
   logic          rsp_err;

   assign rsp_err_o = rsp_err;
`else
   assign rsp_err_o = 1'b0;

   // TIMEOUT/TW only shape the expiry counter; without it they merely need to be sane.
   if (TIMEOUT < 1 || TW < 1) begin : g_bad_timeout_cfg
   end
`endif

   always_comb begin
      state_nxt   = state;
      req_rdy_nxt = req_rdy_o;
      rsp_vld_nxt = rsp_vld_o;
      bus_nxt     = cyc_o;
      adr_nxt     = adr_o;
      we_nxt      = we_o;
      dat_nxt     = dat_o;
      sel_nxt     = sel_o;
      rsp_dat_nxt = rsp_dat_o;
`ifdef WB_TIMEOUT_EN
      cnt_nxt     = cnt;
      rsp_err_nxt = rsp_err;
`endif

      case (state)
         IDLE: begin
            req_rdy_nxt = 1'b1;
            if (req_vld_i) begin
               adr_nxt     = req_adr_i;
               we_nxt      = req_we_i;
               dat_nxt     = req_dat_i;
               sel_nxt     = req_sel_i;
               bus_nxt     = 1'b1;
               req_rdy_nxt = 1'b0;
`ifdef WB_TIMEOUT_EN
               cnt_nxt     = '0;
`endif
               state_nxt   = BUS;
            end
         end

         BUS: begin
            if (ack_i) begin
               bus_nxt     = 1'b0;
               rsp_dat_nxt = we_o ? 32'h0 : dat_i;
               rsp_vld_nxt = 1'b1;
`ifdef WB_TIMEOUT_EN
               rsp_err_nxt = 1'b0;
`endif
               state_nxt   = RESP;
            end
`ifdef WB_TIMEOUT_EN
            // An ack on the expiry cycle takes priority, so expiry is only checked without one.
            else if (cnt == CNT_LAST) begin
               bus_nxt     = 1'b0;
               rsp_dat_nxt = 32'hFFFF_FFFF;
               rsp_err_nxt = 1'b1;
               rsp_vld_nxt = 1'b1;
               state_nxt   = RESP;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + TW'(1);
            end
`endif
         end

         RESP: begin
            if (rsp_rdy_i) begin
               rsp_vld_nxt = 1'b0;
               req_rdy_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         req_rdy_o <= 1'b1;
         rsp_vld_o <= 1'b0;
         cyc_o     <= 1'b0;
         stb_o     <= 1'b0;
         adr_o     <= '0;
         we_o      <= 1'b0;
         dat_o     <= 32'h0;
         sel_o     <= 4'h0;
         rsp_dat_o <= 32'h0;
      end else begin
         state     <= state_nxt;
         req_rdy_o <= req_rdy_nxt;
         rsp_vld_o <= rsp_vld_nxt;
         cyc_o     <= bus_nxt;
         stb_o     <= bus_nxt;
         adr_o     <= adr_nxt;
         we_o      <= we_nxt;
         dat_o     <= dat_nxt;
         sel_o     <= sel_nxt;
         rsp_dat_o <= rsp_dat_nxt;
      end
   end

`ifdef WB_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt     <= '0;
         rsp_err <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         rsp_err <= rsp_err_nxt;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_cyc_ctrl.sv
`default_nettype none
// tb_wb_cyc_ctrl: directed and randomized checks of wb_cyc_ctrl against a transaction-level model.
module tb_wb_cyc_ctrl;

   localparam int AW      = 28;
   localparam int TIMEOUT = 8;
`ifdef WB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_vld_i = 1'b0;
   logic          req_rdy_o;
   logic [AW-1:0] req_adr_i = '0;
   logic          req_we_i = 1'b0;
   logic [31:0]   req_dat_i = 32'h0;
   logic [3:0]    req_sel_i = 4'h0;
   logic          rsp_vld_o;
   logic          rsp_rdy_i = 1'b0;
   logic [31:0]   rsp_dat_o;
   logic          rsp_err_o;
   logic          cyc_o;
   logic          stb_o;
   logic [AW-1:0] adr_o;
   logic          we_o;
   logic [31:0]   dat_o;
   logic [3:0]    sel_o;
   logic          ack_i = 1'b0;
   logic [31:0]   dat_i = 32'h0;

   wb_cyc_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_adr_i(req_adr_i),
      .req_we_i(req_we_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
      .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o), .dat_o(dat_o), .sel_o(sel_o),
      .ack_i(ack_i), .dat_i(dat_i)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 = waiting for a request, 1 = on the bus, 2 = response held.
   int            m_phase = 0;
   int            m_waits = 0;
   bit            m_acc = 1'b0;
   logic [AW-1:0] m_adr;
   logic          m_we;
   logic [31:0]   m_dat;
   logic [3:0]    m_sel;
   logic [31:0]   m_rdat;
   logic          m_err;
   bit            cmp_en = 1'b0;

   always @(posedge clk) begin
      m_acc <= 1'b0;
      if (rst_i) begin
         m_phase <= 0; m_waits <= 0;
         m_adr <= '0; m_we <= 1'b0; m_dat <= 32'h0; m_sel <= 4'h0;
         m_rdat <= 32'h0; m_err <= 1'b0;
      end else if (m_phase == 0) begin
         if (req_vld_i) begin
            m_acc <= 1'b1; m_phase <= 1; m_waits <= 0;
            m_adr <= req_adr_i; m_we <= req_we_i; m_dat <= req_dat_i; m_sel <= req_sel_i;
         end
      end else if (m_phase == 1) begin
         if (ack_i) begin
            m_rdat <= m_we ? 32'h0 : dat_i; m_err <= 1'b0; m_phase <= 2;
         end else if (TO_EN && m_waits == TIMEOUT - 1) begin
            m_rdat <= 32'hFFFF_FFFF; m_err <= 1'b1; m_phase <= 2;
         end else begin
            m_waits <= m_waits + 1;
         end
      end else if (rsp_rdy_i) begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("req_rdy", 32'(req_rdy_o), 32'(m_phase == 0));
         chk("cyc",     32'(cyc_o),     32'(m_phase == 1));
         chk("stb",     32'(stb_o),     32'(m_phase == 1));
         chk("rsp_vld", 32'(rsp_vld_o), 32'(m_phase == 2));
         chk("adr",     32'(adr_o),     32'(m_adr));
         chk("we",      32'(we_o),      32'(m_we));
         chk("dat",     dat_o,          m_dat);
         chk("sel",     32'(sel_o),     32'(m_sel));
         chk("rsp_dat", rsp_dat_o,      m_rdat);
         chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
      end
   end

   // Completes whatever transaction is open, using the model only to decide slave/consumer behaviour.
   task automatic drain(input logic [31:0] d);
      int guard = 0;
      while (m_phase != 0 && guard < 50) begin
         ack_i = (m_phase == 1); dat_i = d; rsp_rdy_i = 1'b1;
         @(negedge clk);
         guard++;
      end
      ack_i = 1'b0; rsp_rdy_i = 1'b0;
      chk("drain_idle", 32'(req_rdy_o), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stb_cnt;
      repeat (2) @(posedge clk);
      #1 cmp_en = 1'b1;

      // Zero-wait read
      @(negedge clk);
      rst_i = 1'b0;
      chk("reset_req_rdy", 32'(req_rdy_o), 32'd1);
      chk("reset_rsp_dat", rsp_dat_o, 32'h0);
      req_vld_i = 1'b1; req_adr_i = 28'h200_0010; req_we_i = 1'b0; req_sel_i = 4'hF;
      @(negedge clk);
      req_vld_i = 1'b0;
      chk("rd_stb_first", 32'(stb_o), 32'd1);
      chk("rd_adr", 32'(adr_o), 32'h0200_0010);
      ack_i = 1'b1; dat_i = 32'hDEADBEEF;
      @(negedge clk);
      ack_i = 1'b0;
      chk("rd_stb_one_cycle", 32'(stb_o), 32'd0);
      chk("rd_rsp_vld", 32'(rsp_vld_o), 32'd1);
      chk("rd_rsp_dat", rsp_dat_o, 32'hDEADBEEF);
      chk("rd_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("model_rd_dat", m_rdat, 32'hDEADBEEF);
      rsp_rdy_i = 1'b1;
      @(negedge clk);
      rsp_rdy_i = 1'b0;
      chk("rd_back_idle", 32'(req_rdy_o), 32'd1);

      // Write with 3 wait states
      req_vld_i = 1'b1; req_adr_i = 28'h100_0004; req_we_i = 1'b1;
      req_dat_i = 32'h12345678; req_sel_i = 4'b0011;
      @(negedge clk);
      req_vld_i = 1'b0; dat_i = 32'hA5A5A5A5;
      stb_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (stb_o) stb_cnt++;
         chk("wr_we", 32'(we_o), 32'd1);
         chk("wr_adr", 32'(adr_o), 32'h0100_0004);
         chk("wr_dat", dat_o, 32'h12345678);
         chk("wr_sel", 32'(sel_o), 32'h3);
         ack_i = (i == 3);
         @(negedge clk);
      end
      ack_i = 1'b0;
      chk("wr_stb_cycles", 32'(stb_cnt), 32'd4);
      chk("wr_stb_drop", 32'(stb_o), 32'd0);
      chk("wr_rsp_vld", 32'(rsp_vld_o), 32'd1);
      chk("wr_rsp_dat", rsp_dat_o, 32'h0);
      chk("model_wr_dat", m_rdat, 32'h0);
      drain(32'h0);

      // Backpressure with the next request held pending
      req_vld_i = 1'b1; req_adr_i = 28'h0AB_CDE0; req_we_i = 1'b0; req_sel_i = 4'hF;
      @(negedge clk);
      req_adr_i = 28'h0123_458; req_we_i = 1'b1; req_dat_i = 32'h600D_F00D; req_sel_i = 4'b1100;
      ack_i = 1'b1; dat_i = 32'hCAFE0001;
      @(negedge clk);
      ack_i = 1'b0; dat_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_vld", 32'(rsp_vld_o), 32'd1);
         chk("bp_rsp_dat", rsp_dat_o, 32'hCAFE0001);
         chk("bp_req_rdy", 32'(req_rdy_o), 32'd0);
         @(negedge clk);
      end
      rsp_rdy_i = 1'b1;
      @(negedge clk);
      rsp_rdy_i = 1'b0;
      chk("bp_after_hs_rdy", 32'(req_rdy_o), 32'd1);
      chk("bp_after_hs_vld", 32'(rsp_vld_o), 32'd0);
      chk("bp_after_hs_stb", 32'(stb_o), 32'd0);
      @(negedge clk);
      req_vld_i = 1'b0;
      chk("b2b_stb", 32'(stb_o), 32'd1);
      chk("b2b_adr", 32'(adr_o), 32'h0012_3458);
      chk("b2b_we", 32'(we_o), 32'd1);
      drain(32'h0);

`ifdef WB_TIMEOUT_EN
      // Timeout without ack, then ack on the expiry cycle
      req_vld_i = 1'b1; req_adr_i = 28'h300_0000; req_we_i = 1'b0;
      @(negedge clk);
      req_vld_i = 1'b0;
      stb_cnt = 0;
      for (int i = 0; i < 20 && !rsp_vld_o; i++) begin
         if (stb_o) stb_cnt++;
         @(negedge clk);
      end
      chk("to_stb_cycles", 32'(stb_cnt), 32'd8);
      chk("to_rsp_vld", 32'(rsp_vld_o), 32'd1);
      chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
      chk("to_rsp_dat", rsp_dat_o, 32'hFFFF_FFFF);
      drain(32'h0);
      req_vld_i = 1'b1;
      @(negedge clk);
      req_vld_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ack_i = (i == 7); dat_i = 32'h0BAD_F00D;
         @(negedge clk);
      end
      ack_i = 1'b0;
      chk("to_ack_wins_vld", 32'(rsp_vld_o), 32'd1);
      chk("to_ack_wins_err", 32'(rsp_err_o), 32'd0);
      chk("to_ack_wins_dat", rsp_dat_o, 32'h0BAD_F00D);
      drain(32'h0);
`else
      // Without the timeout, a silent slave keeps the cycle open
      req_vld_i = 1'b1; req_adr_i = 28'h300_0000; req_we_i = 1'b0;
      @(negedge clk);
      req_vld_i = 1'b0;
      repeat (12) @(negedge clk);
      chk("no_to_stb_held", 32'(stb_o), 32'd1);
      chk("no_to_rsp_vld", 32'(rsp_vld_o), 32'd0);
      drain(32'h7777_0000);
      chk("no_to_err", 32'(rsp_err_o), 32'd0);
`endif

      // Reset during the second strobe cycle, then a late ack
      req_vld_i = 1'b1; req_adr_i = 28'h111_1110; req_we_i = 1'b0;
      @(negedge clk);
      req_vld_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("rst_cyc", 32'(cyc_o), 32'd0);
      chk("rst_stb", 32'(stb_o), 32'd0);
      chk("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy_o), 32'd1);
      ack_i = 1'b1; dat_i = 32'h1234_0000;
      @(negedge clk);
      ack_i = 1'b0;
      chk("late_ack_rsp_vld", 32'(rsp_vld_o), 32'd0);
      chk("late_ack_req_rdy", 32'(req_rdy_o), 32'd1);

      // Spurious ack in IDLE and in RESP
      ack_i = 1'b1; dat_i = 32'h55AA55AA;
      @(negedge clk);
      ack_i = 1'b0;
      chk("spur_idle_dat", rsp_dat_o, 32'h0);
      chk("spur_idle_stb", 32'(stb_o), 32'd0);
      chk("spur_idle_rdy", 32'(req_rdy_o), 32'd1);
      req_vld_i = 1'b1; req_we_i = 1'b0;
      @(negedge clk);
      req_vld_i = 1'b0; ack_i = 1'b1; dat_i = 32'h3C3C3C3C;
      @(negedge clk);
      ack_i = 1'b1; dat_i = 32'hFFFF0000;
      @(negedge clk);
      ack_i = 1'b0;
      chk("spur_resp_dat", rsp_dat_o, 32'h3C3C3C3C);
      chk("spur_resp_vld", 32'(rsp_vld_o), 32'd1);
      chk("spur_resp_stb", 32'(stb_o), 32'd0);
      drain(32'h0);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst_i = ($urandom_range(0, 199) == 0);
         if (!(req_vld_i && !m_acc)) begin
            req_vld_i = ($urandom_range(0, 2) != 0);
            req_adr_i = AW'($urandom);
            req_we_i  = $urandom_range(0, 1) == 1;
            req_dat_i = $urandom;
            req_sel_i = 4'($urandom);
         end
         ack_i     = (m_phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         dat_i     = $urandom;
         rsp_rdy_i = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
      rst_i = 1'b0; req_vld_i = 1'b0;
      @(negedge clk);
      drain(32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
